// File: rtl/ac_in.sv
// ac_in: accumulator input register for the 8-bit processor datapath.
// Holds the operand/result word presented on newData whenever accept is
// sampled high, keeps the word that was held before the latest load, reports
// whether any load has happened since reset, and pulses loaded for one cycle
// after each loading edge. All outputs are registered and there is no
// combinational path from any input to any output.
module ac_in #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] newData,
  input  logic             accept,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_prev,
  output logic             valid,
  output logic             loaded
);

  // Word registers: on a load, shift the held word into data_prev and capture newData.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= RESET_VAL;
      data_prev <= RESET_VAL;
    end else if (accept) begin
      data      <= newData;
      data_prev <= data;
    end
  end

  // Status flags: valid is sticky until reset, loaded follows accept by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      loaded <= 1'b0;
    end else begin
      loaded <= accept;
      if (accept) begin
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ac_in.sv
// tb_ac_in: directed-vector bench for the accumulator input register.
module tb_ac_in;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] newData;
  logic             accept;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_prev;
  logic             valid;
  logic             loaded;

  int unsigned n_vec;
  int unsigned n_bad;

  ac_in #(
    .WIDTH    (WIDTH),
    .RESET_VAL(8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .newData  (newData),
    .accept   (accept),
    .data     (data),
    .data_prev(data_prev),
    .valid    (valid),
    .loaded   (loaded)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [WIDTH-1:0] e_data,
                           input logic [WIDTH-1:0] e_prev, input logic e_valid,
                           input logic e_loaded);
    check({tag, ".data"},      32'(data),      32'(e_data));
    check({tag, ".data_prev"}, 32'(data_prev), 32'(e_prev));
    check({tag, ".valid"},     32'(valid),     32'(e_valid));
    check({tag, ".loaded"},    32'(loaded),    32'(e_loaded));
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    accept  = 1'b1;
    newData = 8'h5A;

    // Reset takes effect before any clock edge, with accept high.
    #1 rst_n = 1'b0;
    #1 check_all("reset_async", 8'h00, 8'h00, 1'b0, 1'b0);
    // Held in reset across edges; accept ignored.
    step();
    step();
    check_all("reset_held", 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // First load.
    accept  = 1'b1;
    newData = 8'h01;
    step();
    check_all("load_01", 8'h01, 8'h00, 1'b1, 1'b1);

    // Hold: newData changes with accept low.
    accept  = 1'b0;
    newData = 8'h02;
    step();
    check_all("hold_1", 8'h01, 8'h00, 1'b1, 1'b0);
    newData = 8'hC3;
    #2 check("hold_no_comb.data", 32'(data), 32'h01);
    step();
    check_all("hold_2", 8'h01, 8'h00, 1'b1, 1'b0);

    // Back-to-back loads.
    accept  = 1'b1;
    newData = 8'h04;
    step();
    check_all("b2b_04", 8'h04, 8'h01, 1'b1, 1'b1);
    newData = 8'h05;
    step();
    check_all("b2b_05", 8'h05, 8'h04, 1'b1, 1'b1);

    // Same-value load still counts as a load.
    newData = 8'h05;
    step();
    check_all("same_05", 8'h05, 8'h05, 1'b1, 1'b1);

    // Async reset mid-cycle with a load pending.
    newData = 8'h77;
    #2 rst_n = 1'b0;
    #1 check_all("mid_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check_all("mid_reset_edge", 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n   = 1'b1;
    newData = 8'hFF;
    step();
    check_all("after_rst_FF", 8'hFF, 8'h00, 1'b1, 1'b1);

    // valid sticky, loaded drops.
    accept  = 1'b0;
    newData = 8'h00;
    step();
    check_all("sticky", 8'hFF, 8'h00, 1'b1, 1'b0);

    // Full-width alternating pattern passes bit-exact.
    accept  = 1'b1;
    newData = 8'hAA;
    step();
    check_all("pattern_AA", 8'hAA, 8'hFF, 1'b1, 1'b1);
    newData = 8'h55;
    step();
    check_all("pattern_55", 8'h55, 8'hAA, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
